multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Finite-state control unit for the multi-cycle MIPS datapath, driven by the instruction register's `op`/`funct`. It produces per-state enables and mux selects for the PC, IR, register file, memory, ALU, and a parametrised multiply/divide unit. The subset adds mult/div/mfhi/mflo and illegal-opcode detection to addu, subu, ori, lw, sw, beq, lui, j, jal and jr. It sits between the IR and the datapath; the datapath owns all storage except the FSM state and the MD cycle counter.

## Interface
Parameters:
- `MULT_CYCLES`, 5: number of cycles spent in S_MD for mult (≥1).
- `DIV_CYCLES`, 10: number of cycles spent in S_MD for div (≥1).
- `EN_MD`, 1: set to 0 to treat mult/div/mfhi/mflo as illegal.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6, `funct` in 6: IR fields. Stable from S_DECODE onward.
- `zero` in 1: ALU equality flag, sampled in S_BRANCH.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1: write enables.
- `NPCsel` out 2: next-PC source. 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs.
- `RegDst` out 2: write-register select. 00 = rt, 01 = rd, 10 = $31.
- `Memback` out 2: write-back data select. 00 = ALU, 01 = memory, 10 = PC+4, 11 = HI/LO.
- `ALUSrc` out 1: 1 selects the extended immediate.
- `EXTop` out 1: 1 selects sign-extend, 0 selects zero-extend.
- `ALUControl` out 3: 000 = add, 001 = sub, 010 = or, 011 = lui (imm<<16).
- `md_start` out 1, `md_div` out 1, `md_busy` out 1, `hilo_we` out 1: MD unit controls.
- `hilo_sel` out 1: 1 selects HI.
- `illegal` out 1: one-cycle pulse in S_DECODE on an unsupported encoding.
- `state` out 4: current state, for debug.

## Operation
- States, in `state` encoding order: S_FETCH = 0, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADDR, S_MEMRD, S_MEMWR, S_WB, S_BRANCH, S_JUMP, S_MD.
- S_FETCH: asserts IRWrite=1, PCWrite=1, NPCsel=00. Next state is S_DECODE.
- S_DECODE: no enables are asserted. The next state depends on the instruction:
  - addu, subu, mfhi, mflo → S_EXEC_R.
  - ori, lui → S_EXEC_I.
  - lw, sw → S_MEMADDR.
  - beq → S_BRANCH.
  - j, jal, jr → S_JUMP.
  - mult, div → S_MD.
  - Anything else → S_FETCH, with `illegal`=1.
- S_EXEC_R: ALUControl is 000 for addu and 001 for subu. Next state is S_WB.
- S_EXEC_I: ALUSrc=1. ori uses EXTop=0 and ALUControl=010; lui uses ALUControl=011. Next state is S_WB.
- S_MEMADDR: ALUSrc=1, EXTop=1, ALUControl=000. Next state is S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: no enables. Next state is S_WB.
- S_MEMWR: MemWrite=1. Next state is S_FETCH.
- S_WB: RegWrite=1. The selects depend on the instruction that reached S_WB:
  - R-type: RegDst=01, Memback=00.
  - mfhi/mflo: RegDst=01, Memback=11, hilo_sel=1 for mfhi.
  - I-type: RegDst=00, Memback=00.
  - lw: RegDst=00, Memback=01.
  - Next state is S_FETCH.
- S_BRANCH: ALUControl=001, NPCsel=01, PCWrite=`zero`. Next state is S_FETCH.
- S_JUMP: PCWrite=1, with NPCsel=11 for jr and 10 otherwise. For jal, also RegWrite=1, RegDst=10, Memback=10. Next state is S_FETCH.
- S_MD:
  - `md_busy`=1 in every cycle of the state.
  - `md_div`=1 for div.
  - `md_start`=1 only when the counter is 0.
  - `hilo_we`=1 only when the counter is N−1, where N is MULT_CYCLES or DIV_CYCLES.
  - The counter increments each cycle. On N−1 the counter clears and the next state is S_FETCH.
  - With N=1, `md_start` and `hilo_we` are asserted in the same single cycle.
- Any output not listed for a state is 0.
- The counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1). It never wraps.

## Timing
- Reset: while `reset`=1, every enable and pulse output is forced to 0 in that same cycle. The following edge loads state=S_FETCH and counter=0. The first cycle after `reset` falls is S_FETCH.
- Reset in any state, including mid-S_MD, aborts the instruction without further writes.
- All outputs are Moore: combinational from the state, the counter and the latched `op`/`funct`. There are no input-to-output paths except `zero`→PCWrite in S_BRANCH.
- CPI, counting the S_FETCH cycle:
  - R-type, I-type, mfhi/mflo: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
  - mult: 2+MULT_CYCLES.
  - div: 2+DIV_CYCLES.
  - illegal: 2.
- `md_busy` is never high outside S_MD. `hilo_we` is asserted exactly once per mult/div.
- With EN_MD=0, the S_MD state is unreachable and the MD outputs stay constant 0.

## Test plan
- Reset held 3 cycles, then released → all enables 0 during reset; state=0 on the first cycle after release, with IRWrite=1 and PCWrite=1.
- lw (op=100011) → state sequence 0,1,4,5,7,0. Memback=01 and RegWrite=1 only in cycle 5.
- beq (op=000100) with zero=0, then again with zero=1 → PCWrite=0, then PCWrite=1, in S_BRANCH; NPCsel=01 in both cases.
- jal (op=000011) → in S_JUMP: PCWrite=1, NPCsel=10, RegWrite=1, RegDst=10, Memback=10. Next state is S_FETCH.
- div (op=0, funct=011010) with DIV_CYCLES=10 → exactly 10 cycles of `md_busy`; `md_start` on the 1st, `hilo_we` on the 10th, `md_div`=1 throughout. Repeat with MULT_CYCLES=1 for mult: one S_MD cycle with `md_start`=`hilo_we`=1.
- op=111111 → `illegal` pulse in S_DECODE, no writes, back in S_FETCH 2 cycles after entry. Separately, reset asserted in the 4th S_MD cycle → no `hilo_we`; S_FETCH with counter 0 on the cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Finite-state control unit for the multi-cycle MIPS datapath. It walks each
// instruction through fetch, decode and the execute/memory/write-back states
// and drives the datapath enables and mux selects. A small cycle counter
// paces the multiply/divide unit while the FSM waits in S_MD.
//
// Supported subset: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, and
// (when EN_MD != 0) mult, div, mfhi, mflo. Anything else raises a one-cycle
// illegal pulse in S_DECODE and returns to fetch.
//
// Parameters:
//   MULT_CYCLES  cycles spent in S_MD for mult (>= 1)
//   DIV_CYCLES   cycles spent in S_MD for div  (>= 1)
//   EN_MD        0 turns mult/div/mfhi/mflo into illegal encodings
//
// Ports:
//   i_clk           single clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_op, i_funct   IR fields, stable from S_DECODE onward
//   i_zero          ALU equality flag, used in S_BRANCH
//   o_PCWrite       PC write enable
//   o_IRWrite       IR write enable
//   o_RegWrite      register file write enable
//   o_MemWrite      data memory write enable
//   o_NPCsel        next PC: 00 PC+4, 01 branch, 10 jump, 11 rs
//   o_RegDst        write register: 00 rt, 01 rd, 10 $31
//   o_Memback       write-back data: 00 ALU, 01 mem, 10 PC+4, 11 HI/LO
//   o_ALUSrc        1 selects the extended immediate
//   o_EXTop         1 sign-extend, 0 zero-extend
//   o_ALUControl    000 add, 001 sub, 010 or, 011 lui
//   o_md_start      MD unit start pulse
//   o_md_div        MD unit divide (vs multiply) select
//   o_md_busy       high for every S_MD cycle
//   o_hilo_we       HI/LO write enable, once per mult/div
//   o_hilo_sel      1 selects HI for mfhi
//   o_illegal       unsupported encoding seen in S_DECODE
//   o_state         current FSM state, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int EN_MD       = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic       o_PCWrite,
  output logic       o_IRWrite,
  output logic       o_RegWrite,
  output logic       o_MemWrite,
  output logic [1:0] o_NPCsel,
  output logic [1:0] o_RegDst,
  output logic [1:0] o_Memback,
  output logic       o_ALUSrc,
  output logic       o_EXTop,
  output logic [2:0] o_ALUControl,
  output logic       o_md_start,
  output logic       o_md_div,
  output logic       o_md_busy,
  output logic       o_hilo_we,
  output logic       o_hilo_sel,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  // State encoding is visible on o_state, so the values are fixed.
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_EXEC_I  = 4'd3;
  localparam logic [3:0] S_MEMADDR = 4'd4;
  localparam logic [3:0] S_MEMRD   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_MD      = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam bit MD_ON = (EN_MD != 0);

  // The counter only has to reach N-1 of the longer operation, so sizing it
  // for max(N)+1 values guarantees it never wraps.
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_mdCnt;

  logic [3:0]       w_nextState;
  logic [CNT_W-1:0] w_nextCnt;

  logic w_isRtype;
  logic w_isAddu;
  logic w_isSubu;
  logic w_isMfhi;
  logic w_isMflo;
  logic w_isMult;
  logic w_isDiv;
  logic w_isJr;
  logic w_isOri;
  logic w_isLui;
  logic w_isLw;
  logic w_isSw;
  logic w_isBeq;
  logic w_isJ;
  logic w_isJal;
  logic w_isLegal;

  logic [CNT_W-1:0] w_mdLast;
  logic             w_cntAtZero;
  logic             w_cntAtLast;

  // Instruction decode straight from the IR fields. The MD-related
  // instructions are qualified by MD_ON so that disabling the MD unit turns
  // them into illegal encodings and S_MD can never be entered.
  always_comb begin
    w_isRtype = (i_op == OP_RTYPE);
    w_isAddu  = w_isRtype && (i_funct == FN_ADDU);
    w_isSubu  = w_isRtype && (i_funct == FN_SUBU);
    w_isJr    = w_isRtype && (i_funct == FN_JR);
    w_isMfhi  = MD_ON && w_isRtype && (i_funct == FN_MFHI);
    w_isMflo  = MD_ON && w_isRtype && (i_funct == FN_MFLO);
    w_isMult  = MD_ON && w_isRtype && (i_funct == FN_MULT);
    w_isDiv   = MD_ON && w_isRtype && (i_funct == FN_DIV);
    w_isOri   = (i_op == OP_ORI);
    w_isLui   = (i_op == OP_LUI);
    w_isLw    = (i_op == OP_LW);
    w_isSw    = (i_op == OP_SW);
    w_isBeq   = (i_op == OP_BEQ);
    w_isJ     = (i_op == OP_J);
    w_isJal   = (i_op == OP_JAL);
    w_isLegal = w_isAddu || w_isSubu || w_isJr || w_isMfhi || w_isMflo ||
                w_isMult || w_isDiv || w_isOri || w_isLui || w_isLw ||
                w_isSw || w_isBeq || w_isJ || w_isJal;
  end

  // The MD dwell length depends on which operation is in flight; the start
  // and HI/LO write pulses key off the first and last counter values.
  always_comb begin
    w_mdLast    = w_isDiv ? DIV_LAST : MULT_LAST;
    w_cntAtZero = (r_mdCnt == '0);
    w_cntAtLast = (r_mdCnt == w_mdLast);
  end

  // Next-state logic. Every instruction ends by returning to S_FETCH; the
  // decode state fans out by instruction class, and an unrecognised
  // encoding drops straight back to fetch. Unused encodings also recover
  // to fetch.
  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:   w_nextState = S_DECODE;
      S_DECODE: begin
        if (w_isAddu || w_isSubu || w_isMfhi || w_isMflo)
          w_nextState = S_EXEC_R;
        else if (w_isOri || w_isLui)
          w_nextState = S_EXEC_I;
        else if (w_isLw || w_isSw)
          w_nextState = S_MEMADDR;
        else if (w_isBeq)
          w_nextState = S_BRANCH;
        else if (w_isJ || w_isJal || w_isJr)
          w_nextState = S_JUMP;
        else if (w_isMult || w_isDiv)
          w_nextState = S_MD;
        else
          w_nextState = S_FETCH;
      end
      S_EXEC_R:  w_nextState = S_WB;
      S_EXEC_I:  w_nextState = S_WB;
      S_MEMADDR: w_nextState = w_isLw ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_nextState = S_WB;
      S_MEMWR:   w_nextState = S_FETCH;
      S_WB:      w_nextState = S_FETCH;
      S_BRANCH:  w_nextState = S_FETCH;
      S_JUMP:    w_nextState = S_FETCH;
      S_MD:      w_nextState = w_cntAtLast ? S_FETCH : S_MD;
      default:   w_nextState = S_FETCH;
    endcase
  end

  // The MD counter advances once per S_MD cycle and is cleared on the last
  // one, so it is always zero on entry to the next mult/div.
  always_comb begin
    w_nextCnt = '0;
    if (r_state == S_MD && !w_cntAtLast)
      w_nextCnt = r_mdCnt + CNT_W'(1);
  end

  // State and counter registers with synchronous reset; a reset in any
  // state, including mid-multiply/divide, simply restarts at fetch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_mdCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_mdCnt <= w_nextCnt;
    end
  end

  // Moore output decode from state, counter and IR fields. While reset is
  // high every control output is held at zero in that same cycle so an
  // aborted instruction cannot write anything. The only input-to-output
  // path besides reset is zero -> PCWrite in S_BRANCH.
  always_comb begin
    o_PCWrite    = 1'b0;
    o_IRWrite    = 1'b0;
    o_RegWrite   = 1'b0;
    o_MemWrite   = 1'b0;
    o_NPCsel     = 2'b00;
    o_RegDst     = 2'b00;
    o_Memback    = 2'b00;
    o_ALUSrc     = 1'b0;
    o_EXTop      = 1'b0;
    o_ALUControl = 3'b000;
    o_md_start   = 1'b0;
    o_md_div     = 1'b0;
    o_md_busy    = 1'b0;
    o_hilo_we    = 1'b0;
    o_hilo_sel   = 1'b0;
    o_illegal    = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_FETCH: begin
          o_IRWrite = 1'b1;
          o_PCWrite = 1'b1;
          o_NPCsel  = 2'b00;
        end
        S_DECODE: begin
          o_illegal = !w_isLegal;
        end
        S_EXEC_R: begin
          o_ALUControl = w_isSubu ? 3'b001 : 3'b000;
        end
        S_EXEC_I: begin
          o_ALUSrc = 1'b1;
          if (w_isLui) begin
            o_ALUControl = 3'b011;
          end else begin
            o_ALUControl = 3'b010;
            o_EXTop      = 1'b0;
          end
        end
        S_MEMADDR: begin
          o_ALUSrc     = 1'b1;
          o_EXTop      = 1'b1;
          o_ALUControl = 3'b000;
        end
        S_MEMWR: begin
          o_MemWrite = 1'b1;
        end
        S_WB: begin
          o_RegWrite = 1'b1;
          if (w_isMfhi || w_isMflo) begin
            o_RegDst   = 2'b01;
            o_Memback  = 2'b11;
            o_hilo_sel = w_isMfhi;
          end else if (w_isAddu || w_isSubu) begin
            o_RegDst  = 2'b01;
            o_Memback = 2'b00;
          end else if (w_isLw) begin
            o_RegDst  = 2'b00;
            o_Memback = 2'b01;
          end else begin
            o_RegDst  = 2'b00;
            o_Memback = 2'b00;
          end
        end
        S_BRANCH: begin
          o_ALUControl = 3'b001;
          o_NPCsel     = 2'b01;
          o_PCWrite    = i_zero;
        end
        S_JUMP: begin
          o_PCWrite = 1'b1;
          o_NPCsel  = w_isJr ? 2'b11 : 2'b10;
          if (w_isJal) begin
            o_RegWrite = 1'b1;
            o_RegDst   = 2'b10;
            o_Memback  = 2'b10;
          end
        end
        S_MD: begin
          o_md_busy  = MD_ON;
          o_md_div   = w_isDiv;
          o_md_start = MD_ON && w_cntAtZero;
          o_hilo_we  = MD_ON && w_cntAtLast;
        end
        default: begin
          o_illegal = 1'b0;
        end
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl (MULT_CYCLES=1, DIV_CYCLES=10). For
// each instruction the expected per-cycle control word is derived from the
// instruction's class and pushed to a queue; the queue is then drained one
// entry per clock, comparing against the DUT at the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       PCWrite, IRWrite, RegWrite, MemWrite;
  logic [1:0] NPCsel, RegDst, Memback;
  logic       ALUSrc, EXTop;
  logic [2:0] ALUControl;
  logic       mdStart, mdDiv, mdBusy, hiloWe, hiloSel, illegal;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] state;
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic [1:0] npc;
    logic [1:0] rdst;
    logic [1:0] mb;
    logic       alusrc;
    logic       ext;
    logic [2:0] aluc;
    logic       mds;
    logic       mdd;
    logic       mdb;
    logic       hwe;
    logic       hsel;
    logic       ill;
  } ctrl_t;

  typedef struct {
    ctrl_t v;
    string tag;
  } exp_t;

  exp_t  expQ[$];
  int    errors = 0;
  int    checks = 0;
  ctrl_t observed;

  multicycle_ctrl #(
    .MULT_CYCLES(1),
    .DIV_CYCLES (10),
    .EN_MD      (1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_op        (op),
    .i_funct     (funct),
    .i_zero      (zero),
    .o_PCWrite   (PCWrite),
    .o_IRWrite   (IRWrite),
    .o_RegWrite  (RegWrite),
    .o_MemWrite  (MemWrite),
    .o_NPCsel    (NPCsel),
    .o_RegDst    (RegDst),
    .o_Memback   (Memback),
    .o_ALUSrc    (ALUSrc),
    .o_EXTop     (EXTop),
    .o_ALUControl(ALUControl),
    .o_md_start  (mdStart),
    .o_md_div    (mdDiv),
    .o_md_busy   (mdBusy),
    .o_hilo_we   (hiloWe),
    .o_hilo_sel  (hiloSel),
    .o_illegal   (illegal),
    .o_state     (state)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Pack the DUT outputs in the same field order as ctrl_t.
  assign observed = {state, PCWrite, IRWrite, RegWrite, MemWrite, NPCsel,
                     RegDst, Memback, ALUSrc, EXTop, ALUControl, mdStart,
                     mdDiv, mdBusy, hiloWe, hiloSel, illegal};

  function automatic ctrl_t blank(input logic [3:0] st);
    ctrl_t c;
    c = '0;
    c.state = st;
    return c;
  endfunction

  task automatic push(input ctrl_t c, input string tag);
    exp_t e;
    e.v = c;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic pushMd(input int n, input logic isDiv, input string name);
    ctrl_t c;
    for (int k = 0; k < n; k++) begin
      c = blank(4'd10);
      c.mdb = 1'b1;
      c.mdd = isDiv;
      c.mds = (k == 0);
      c.hwe = (k == n - 1);
      push(c, $sformatf("%s/md%0d", name, k + 1));
    end
  endtask

  // Drives one instruction's IR fields and pushes its expected trace,
  // starting with the S_FETCH cycle the caller is currently in.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input string name);
    ctrl_t c;
    op = o;
    funct = f;
    zero = z;
    c = blank(4'd0); c.pcw = 1'b1; c.irw = 1'b1;
    push(c, {name, "/fetch"});
    c = blank(4'd1);
    case (o)
      6'b000000: begin
        case (f)
          6'b100001, 6'b100011, 6'b010000, 6'b010010: begin
            push(c, {name, "/decode"});
            c = blank(4'd2);
            if (f == 6'b100011) c.aluc = 3'b001;
            push(c, {name, "/execR"});
            c = blank(4'd7); c.rw = 1'b1; c.rdst = 2'b01;
            if (f == 6'b010000 || f == 6'b010010) c.mb = 2'b11;
            if (f == 6'b010000) c.hsel = 1'b1;
            push(c, {name, "/wb"});
          end
          6'b001000: begin
            push(c, {name, "/decode"});
            c = blank(4'd9); c.pcw = 1'b1; c.npc = 2'b11;
            push(c, {name, "/jump"});
          end
          6'b011000: begin
            push(c, {name, "/decode"});
            pushMd(1, 1'b0, name);
          end
          6'b011010: begin
            push(c, {name, "/decode"});
            pushMd(10, 1'b1, name);
          end
          default: begin
            c.ill = 1'b1;
            push(c, {name, "/decode"});
          end
        endcase
      end
      6'b001101, 6'b001111: begin
        push(c, {name, "/decode"});
        c = blank(4'd3); c.alusrc = 1'b1;
        c.aluc = (o == 6'b001111) ? 3'b011 : 3'b010;
        push(c, {name, "/execI"});
        c = blank(4'd7); c.rw = 1'b1;
        push(c, {name, "/wb"});
      end
      6'b100011: begin
        push(c, {name, "/decode"});
        c = blank(4'd4); c.alusrc = 1'b1; c.ext = 1'b1;
        push(c, {name, "/memaddr"});
        push(blank(4'd5), {name, "/memrd"});
        c = blank(4'd7); c.rw = 1'b1; c.mb = 2'b01;
        push(c, {name, "/wb"});
      end
      6'b101011: begin
        push(c, {name, "/decode"});
        c = blank(4'd4); c.alusrc = 1'b1; c.ext = 1'b1;
        push(c, {name, "/memaddr"});
        c = blank(4'd6); c.mw = 1'b1;
        push(c, {name, "/memwr"});
      end
      6'b000100: begin
        push(c, {name, "/decode"});
        c = blank(4'd8); c.aluc = 3'b001; c.npc = 2'b01; c.pcw = z;
        push(c, {name, "/branch"});
      end
      6'b000010, 6'b000011: begin
        push(c, {name, "/decode"});
        c = blank(4'd9); c.pcw = 1'b1; c.npc = 2'b10;
        if (o == 6'b000011) begin
          c.rw = 1'b1; c.rdst = 2'b10; c.mb = 2'b10;
        end
        push(c, {name, "/jump"});
      end
      default: begin
        c.ill = 1'b1;
        push(c, {name, "/decode"});
      end
    endcase
  endtask

  // Drains the scoreboard, one expected control word per clock, sampled on
  // the falling edge.
  task automatic checkOutput();
    exp_t e;
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      assert (observed === e.v)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, observed, e.v);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] multicycle_ctrl directed run");

    // Reset held for three cycles: all controls low, state at fetch.
    for (int i = 0; i < 3; i++) push(blank(4'd0), $sformatf("reset%0d", i));
    checkOutput();
    nextCycle();
    reset = 1'b0;

    applyStimulus(6'b000000, 6'b100001, 1'b0, "addu");  checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b100011, 1'b0, "subu");  checkOutput(); nextCycle();
    applyStimulus(6'b001101, 6'b000000, 1'b0, "ori");   checkOutput(); nextCycle();
    applyStimulus(6'b001111, 6'b000000, 1'b0, "lui");   checkOutput(); nextCycle();
    applyStimulus(6'b100011, 6'b000000, 1'b0, "lw");    checkOutput(); nextCycle();
    applyStimulus(6'b101011, 6'b000000, 1'b0, "sw");    checkOutput(); nextCycle();
    applyStimulus(6'b000100, 6'b000000, 1'b0, "beqZ0"); checkOutput(); nextCycle();
    applyStimulus(6'b000100, 6'b000000, 1'b1, "beqZ1"); checkOutput(); nextCycle();
    applyStimulus(6'b000010, 6'b000000, 1'b0, "j");     checkOutput(); nextCycle();
    applyStimulus(6'b000011, 6'b000000, 1'b0, "jal");   checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b001000, 1'b0, "jr");    checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b010000, 1'b0, "mfhi");  checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b010010, 1'b0, "mflo");  checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b011010, 1'b0, "div");   checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b011000, 1'b0, "mult");  checkOutput(); nextCycle();
    applyStimulus(6'b111111, 6'b000000, 1'b0, "illOp"); checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b000000, 1'b0, "illFn"); checkOutput(); nextCycle();

    // div aborted by reset in its fourth S_MD cycle: fetch, decode and three
    // MD cycles run normally, then the reset cycle must show no writes.
    applyStimulus(6'b000000, 6'b011010, 1'b0, "divAbort");
    while (expQ.size() > 5) void'(expQ.pop_back());
    checkOutput();
    nextCycle();
    reset = 1'b1;
    push(blank(4'd10), "divAbort/resetInMd");
    checkOutput();
    nextCycle();
    reset = 1'b0;

    // A full div right after release proves the counter restarted at zero.
    applyStimulus(6'b000000, 6'b011010, 1'b0, "divAfterRst"); checkOutput(); nextCycle();
    applyStimulus(6'b000000, 6'b100001, 1'b0, "adduEnd");     checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
